// File: rtl/lives_hud_ctrl.sv
// Lives HUD: tracks the player's life count through PLAYING/DYING/GAME_OVER
// and renders one 24x24 sprite icon per life through a two-stage pixel pipeline.
module lives_hud_ctrl #(
  parameter int HUD_X        = 16,
  parameter int HUD_Y        = 8,
  parameter int ICON_PITCH   = 28,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 5,
  parameter int DYING_FRAMES = 60,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       lose_life,
  input  logic       add_life,
  input  logic       new_game,
  output logic [9:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic       live_pixel_on,
  output logic [3:0] live_color_idx,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int ICON_SIZE = 24;
  localparam int FW        = $clog2(DYING_FRAMES + 1);
  localparam int BW        = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {PLAYING, DYING, GAME_OVER} state_t;

  state_t         state, state_n;
  logic [2:0]     lives_n;
  logic [FW-1:0]  frame_cnt, frame_cnt_n;
  logic [BW-1:0]  blink_cnt, blink_cnt_n;
  logic           blink_on, blink_on_n;

  logic [MAX_LIVES-1:0] icon_en;
  logic                 hit_c, hit1, hit2;
  logic [9:0]           addr_c;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= PLAYING;
      lives     <= 3'(START_LIVES);
      frame_cnt <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      state     <= state_n;
      lives     <= lives_n;
      frame_cnt <= frame_cnt_n;
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path can leave one unassigned and infer a latch.
    state_n     = state;
    lives_n     = lives;
    frame_cnt_n = frame_cnt;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;

    if (new_game) begin
      state_n     = PLAYING;
      lives_n     = 3'(START_LIVES);
      frame_cnt_n = '0;
      blink_cnt_n = '0;
      blink_on_n  = 1'b0;
    end else begin
      unique case (state)
        PLAYING: begin
          // A simultaneous add_life is dropped when a life is lost.
          if (lose_life && lives != 3'd0) begin
            state_n     = DYING;
            lives_n     = lives - 3'd1;
            frame_cnt_n = FW'(DYING_FRAMES);
            blink_cnt_n = '0;
            blink_on_n  = 1'b1;
          end else if (add_life && lives < 3'(MAX_LIVES)) begin
            lives_n = lives + 3'd1;
          end
        end
        DYING: begin
          if (frame_start) begin
            if (frame_cnt <= FW'(1)) begin
              frame_cnt_n = '0;
              blink_cnt_n = '0;
              blink_on_n  = 1'b0;
              state_n     = (lives == 3'd0) ? GAME_OVER : PLAYING;
            end else begin
              frame_cnt_n = frame_cnt - FW'(1);
              if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_n = '0;
                blink_on_n  = ~blink_on;
              end else begin
                blink_cnt_n = blink_cnt + BW'(1);
              end
            end
          end
        end
        GAME_OVER: lives_n = '0;
        default:   state_n = PLAYING;
      endcase
    end
  end

  // The icon just lost blinks in place while dying.
  always_comb begin
    icon_en = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      icon_en[i] = (i < int'(lives)) ||
                   (state == DYING && i == int'(lives) && blink_on);
    end
  end

  // ICON_PITCH >= ICON_SIZE keeps icons disjoint, so at most one can match.
  always_comb begin
    hit_c  = 1'b0;
    addr_c = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (int'(DrawX) >= HUD_X + i * ICON_PITCH &&
          int'(DrawX) <  HUD_X + i * ICON_PITCH + ICON_SIZE &&
          int'(DrawY) >= HUD_Y && int'(DrawY) < HUD_Y + ICON_SIZE &&
          icon_en[i]) begin
        hit_c  = 1'b1;
        addr_c = 10'((int'(DrawY) - HUD_Y) * ICON_SIZE +
                     (int'(DrawX) - HUD_X - i * ICON_PITCH));
      end
    end
  end

  // hit2 lines up with rom_data, which the ROM returns one cycle after rom_addr.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      rom_addr <= '0;
    end else begin
      hit1     <= hit_c;
      hit2     <= hit1;
      rom_addr <= addr_c;
    end
  end

  assign live_color_idx = rom_data;
  assign live_pixel_on  = hit2 && (rom_data != 4'd0);
  assign game_over      = (state == GAME_OVER);

endmodule

// File: tb/tb_lives_hud_ctrl.sv
// Self-checking bench for lives_hud_ctrl: a pixel scoreboard fed by a small
// behavioural model, plus directed checks of the life/blink/game-over flow.
module tb_lives_hud_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_start, lose_life, add_life, new_game;
  logic [9:0] DrawX, DrawY;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic       live_pixel_on;
  logic [3:0] live_color_idx;
  logic [2:0] lives;
  logic       game_over;

  lives_hud_ctrl dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_start    (frame_start),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .lose_life      (lose_life),
    .add_life       (add_life),
    .new_game       (new_game),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .live_pixel_on  (live_pixel_on),
    .live_color_idx (live_color_idx),
    .lives          (lives),
    .game_over      (game_over)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM stand-in; address 9 holds the transparent colour 0.
  function automatic logic [3:0] rom_val(input logic [9:0] a);
    logic [9:0] t;
    t = a * 10'd5 + 10'd3;
    return t[3:0];
  endfunction

  always @(posedge Clk) rom_data <= rom_val(rom_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    string      tag;
    logic [9:0] addr;
    logic       on;
    logic [3:0] idx;
  } exp_t;

  exp_t addr_q[$];
  exp_t pix_q[$];

  // Behavioural model: 0 = playing, 1 = dying, 2 = game over
  int m_state, m_lives, m_frame, m_bcnt;
  bit m_blink;

  function automatic void model_reset();
    m_state = 0; m_lives = 3; m_frame = 0; m_bcnt = 0; m_blink = 1'b0;
  endfunction

  function automatic exp_t model_px(input int x, input int y);
    exp_t e;
    e.tag  = $sformatf("px(%0d,%0d)", x, y);
    e.addr = '0;
    e.on   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int x0 = 16 + 28 * i;
      if (x >= x0 && x < x0 + 24 && y >= 8 && y < 32 &&
          (i < m_lives || (m_state == 1 && i == m_lives && m_blink))) begin
        e.addr = 10'((y - 8) * 24 + (x - x0));
        e.on   = 1'b1;
      end
    end
    e.idx = rom_val(e.addr);
    e.on  = e.on && (e.idx != 4'd0);
    return e;
  endfunction

  function automatic void model_step(input bit fs, input bit ll, input bit al, input bit ng);
    if (ng) model_reset();
    else if (m_state == 0) begin
      if (ll && m_lives > 0) begin
        m_lives--; m_frame = 60; m_bcnt = 0; m_blink = 1'b1; m_state = 1;
      end else if (al && m_lives < 5) m_lives++;
    end else if (m_state == 1 && fs) begin
      if (m_frame <= 1) begin
        m_frame = 0; m_bcnt = 0; m_blink = 1'b0;
        m_state = (m_lives == 0) ? 2 : 0;
      end else begin
        m_frame--;
        if (m_bcnt == 7) begin m_bcnt = 0; m_blink = !m_blink; end
        else m_bcnt++;
      end
    end
  endfunction

  // One cycle: score the pipeline outputs, then drive the next pixel and pulses.
  task automatic tick(input int x, input int y, input bit fs, input bit ll, input bit al, input bit ng);
    exp_t e;
    @(negedge Clk);
    if (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      check({e.tag, "/pix"}, 32'(live_pixel_on), 32'(e.on));
      check({e.tag, "/idx"}, 32'(live_color_idx), 32'(e.idx));
    end
    if (addr_q.size() > 0) begin
      e = addr_q.pop_front();
      check({e.tag, "/addr"}, 32'(rom_addr), 32'(e.addr));
      pix_q.push_back(e);
    end
    check("lives", 32'(lives), 32'(m_lives));
    check("game_over", 32'(game_over), 32'(m_state == 2));
    addr_q.push_back(model_px(x, y));
    DrawX = 10'(x); DrawY = 10'(y);
    frame_start = fs; lose_life = ll; add_life = al; new_game = ng;
    model_step(fs, ll, al, ng);
  endtask

  task automatic drive(input int x, input int y);
    tick(x, y, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n, input int x, input int y);
    repeat (n) begin
      tick(x, y, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(x, y, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    frame_start = 1'b0; lose_life = 1'b0; add_life = 1'b0; new_game = 1'b0;
    DrawX = 10'd1000; DrawY = 10'd1000;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_pix", 32'(live_pixel_on), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_gover", 32'(game_over), 32'd0);
    Reset_n = 1'b1;

    // Icon 0 origin, pipeline latency
    drive(16, 8);
    drive(1000, 1000);
    check("org_addr", 32'(rom_addr), 32'd0);
    drive(1000, 1000);
    check("org_pix", 32'(live_pixel_on), 32'd1);

    // Address corners, gap, transparency, disabled icon
    drive(67, 31);
    drive(1000, 1000);
    check("addr_575", 32'(rom_addr), 32'd575);
    drive(40, 8);
    drive(1000, 1000);
    check("gap_addr", 32'(rom_addr), 32'd0);
    check("gap_pix", 32'(live_pixel_on), 32'd0);
    drive(25, 8);
    drive(1000, 1000);
    drive(1000, 1000);
    check("transp_pix", 32'(live_pixel_on), 32'd0);
    for (int i = 0; i < 5; i++) drive(16 + 28 * i + 3, 10 + i);
    drive(17, 8); drive(16, 9); drive(39, 8); drive(15, 8); drive(16, 32);

    // Lose a life with a coincident frame_start, then watch icon 2 blink
    tick(1000, 1000, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(77, 8);
    check("ll_lives", 32'(lives), 32'd2);
    frames(4, 77, 8); drive(77, 8); drive(77, 8);
    check("blink_vis", 32'(live_pixel_on), 32'd1);
    frames(4, 77, 8); drive(77, 8); drive(77, 8);
    check("blink_hid", 32'(live_pixel_on), 32'd0);
    tick(77, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(77, 8);
    check("dying_add_ign", 32'(lives), 32'd2);
    frames(8, 77, 8); drive(77, 8); drive(77, 8);
    check("blink_vis2", 32'(live_pixel_on), 32'd1);
    frames(43, 77, 8);
    tick(77, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(77, 8);
    check("dying_ll_ign", 32'(lives), 32'd2);
    frames(1, 77, 8);
    drive(77, 8); drive(77, 8);
    check("after60_icon2", 32'(live_pixel_on), 32'd0);

    // Down to game over
    tick(1000, 1000, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1000, 1000);
    check("ll_2to1", 32'(lives), 32'd1);
    frames(60, 45, 20);
    tick(1000, 1000, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(59, 20, 12);
    check("go_not_yet", 32'(game_over), 32'd0);
    frames(1, 20, 12);
    check("go_set", 32'(game_over), 32'd1);
    check("go_lives", 32'(lives), 32'd0);
    tick(16, 8, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(16, 8); drive(16, 8);
    check("go_ign", 32'(lives), 32'd0);
    tick(16, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(16, 8);
    check("ng_lives", 32'(lives), 32'd3);
    check("ng_gover", 32'(game_over), 32'd0);

    // Saturation and lose/add collision
    repeat (5) begin
      tick(128, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(128, 8);
    end
    check("sat5", 32'(lives), 32'd5);
    tick(128, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(60, 128, 8);
    check("back_to_4", 32'(lives), 32'd4);
    tick(1000, 1000, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1000, 1000);
    check("ll_wins", 32'(lives), 32'd3);
    frames(60, 72, 30);

    // Reset mid-DYING with hits in flight
    tick(16, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(10, 16, 8);
    drive(16, 8);
    check("pre_rst_pix", 32'(live_pixel_on), 32'd1);
    #2;
    Reset_n = 1'b0;
    DrawX = 10'd1000; DrawY = 10'd1000;
    #1;
    check("rst2_pix", 32'(live_pixel_on), 32'd0);
    check("rst2_addr", 32'(rom_addr), 32'd0);
    check("rst2_lives", 32'(lives), 32'd3);
    check("rst2_gover", 32'(game_over), 32'd0);
    addr_q.delete();
    pix_q.delete();
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    addr_q.push_back(model_px(1000, 1000));
    drive(1000, 1000);
    drive(1000, 1000);
    drive(1000, 1000);
    // The post-reset state must be PLAYING with a fresh frame counter.
    tick(16, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(60, 16, 8);
    drive(1000, 1000); drive(1000, 1000); drive(1000, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
